// File: rtl/register_file_param.sv
// register_file_param: parametrised 2-read / 1-write register file with a sequential clear engine.
// Latency: reads are combinational (zero cycles); writes land on the rising edge; the sweep takes NUM_REGS cycles.
// Backpressure: ready=0 during the sweep; writes offered then (or alongside clr) are discarded and flagged on wr_drop.
//
// Ports:
//   clk, rst (async active-low), clr (clear request, sampled in IDLE only)
//   WE3/A3/WD3 : synchronous write port
//   A1/RD1, A2/RD2 : combinational read ports, forced to 0 while ready=0
//   ready : array initialised; wr_drop : one-cycle pulse after a discarded write
//
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of an
// accepted write onto any read port addressing the same entry.
module register_file_param #(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              ready,
  output logic              wr_drop
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  // idx carries one extra bit so the terminal compare cannot wrap.
  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] LP_NUM  = (ADDR_W+1)'(NUM_REGS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   w_idx_nxt;
  logic              r_wr_drop;
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic              w_idle;
  logic              w_a3_ok;
  logic              w_wr_acc;
  logic              w_drop_req;
  logic [DATA_W-1:0] w_arr1;
  logic [DATA_W-1:0] w_arr2;

  assign w_idle = (r_state == S_IDLE);

  // Out-of-range addresses and the hardwired zero register are silently ignored.
  assign w_a3_ok   = ({1'b0, A3} < LP_NUM) && !((ZERO_REG != 0) && (A3 == '0));
  assign w_wr_acc  = w_idle && !clr && WE3 && w_a3_ok;
  // Clear always wins over a concurrent write; the loss is reported, not the ignore.
  assign w_drop_req = WE3 && (!w_idle || clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_CLEAR;
      r_idx     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wr_drop <= w_drop_req;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_CLEAR: begin
        // clr is deliberately not looked at here: the sweep never restarts.
        w_idx_nxt = r_idx + (ADDR_W+1)'(1);
        if (r_idx == LP_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((r_state == S_CLEAR) && (r_idx == (ADDR_W+1)'(i))) begin
        r_mem[i] <= '0;
      end else if (w_wr_acc && (A3 == ADDR_W'(i))) begin
        r_mem[i] <= WD3;
      end
    end
  end

  // Array read muxes; unmatched (out-of-range) addresses fall through to 0.
  always_comb begin
    w_arr1 = '0;
    w_arr2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (A1 == ADDR_W'(i)) w_arr1 = r_mem[i];
        if (A2 == ADDR_W'(i)) w_arr2 = r_mem[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // w_wr_acc already excludes ignored/dropped writes and register 0 when hardwired.
  assign w_fwd1 = w_wr_acc && (A3 == A1);
  assign w_fwd2 = w_wr_acc && (A3 == A2);

  assign RD1 = !w_idle ? '0 : (w_fwd1 ? WD3 : w_arr1);
  assign RD2 = !w_idle ? '0 : (w_fwd2 ? WD3 : w_arr2);
`else
  assign RD1 = w_idle ? w_arr1 : '0;
  assign RD2 = w_idle ? w_arr2 : '0;
`endif

  assign ready   = w_idle;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: directed vectors, expectations queued by the
// stimulus thread and checked by a separate negedge monitor.
module tb_register_file_param;

  localparam int DW = 19;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  // DUT a: default parameters (16 regs, hardwired zero)
  logic          a_clr, a_we;
  logic [AW-1:0] a_a1, a_a2, a_a3;
  logic [DW-1:0] a_wd, a_rd1, a_rd2;
  logic          a_ready, a_drop;
  // DUT b: 12 regs, register 0 is a normal register
  logic          b_clr, b_we;
  logic [AW-1:0] b_a1, b_a2, b_a3;
  logic [DW-1:0] b_wd, b_rd1, b_rd2;
  logic          b_ready, b_drop;

  register_file_param u_dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .WE3(a_we),
    .A1(a_a1), .A2(a_a2), .A3(a_a3), .WD3(a_wd),
    .RD1(a_rd1), .RD2(a_rd2), .ready(a_ready), .wr_drop(a_drop)
  );

  register_file_param #(
    .DATA_W(19), .ADDR_W(4), .NUM_REGS(12), .ZERO_REG(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .WE3(b_we),
    .A1(b_a1), .A2(b_a2), .A3(b_a3), .WD3(b_wd),
    .RD1(b_rd1), .RD2(b_rd2), .ready(b_ready), .wr_drop(b_drop)
  );

  typedef enum int {K_RD1, K_RD2, K_RDY, K_DROP} kind_t;
  typedef struct {
    int            cyc;
    int            dut;
    kind_t         kind;
    logic [DW-1:0] val;
    string         name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_cnt = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int dut, input kind_t k, input logic [DW-1:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.dut  = dut;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] sample(input int dut, input kind_t k);
    logic [DW-1:0] r;
    r = '0;
    if (dut == 0) begin
      case (k)
        K_RD1:   r = a_rd1;
        K_RD2:   r = a_rd2;
        K_RDY:   r = DW'(a_ready);
        default: r = DW'(a_drop);
      endcase
    end else begin
      case (k)
        K_RD1:   r = b_rd1;
        K_RD2:   r = b_rd2;
        K_RDY:   r = DW'(b_ready);
        default: r = DW'(b_drop);
      endcase
    end
    return r;
  endfunction

  // Monitor: compares every expectation belonging to the current cycle.
  always @(negedge clk) begin
    exp_t          e;
    logic [DW-1:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      e   = sb_q.pop_front();
      act = sample(e.dut, e.kind);
      n_vec++;
      if (e.cyc != cyc_cnt || act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.val, e.cyc);
      end
    end
  end

  function automatic logic [DW-1:0] fillv(input int i);
    return DW'(i * 32'h4321);
  endfunction

  logic [DW-1:0] same_cyc_exp;

  initial begin
    rst = 1'b0;
    a_clr = 0; a_we = 0; a_a1 = 5; a_a2 = 9; a_a3 = 0; a_wd = '0;
    b_clr = 0; b_we = 0; b_a1 = 3; b_a2 = 0; b_a3 = 0; b_wd = '0;
    tick();
    tick();
    // Reset state
    expect_v(0, K_RDY,  0, "rst_ready_a");
    expect_v(0, K_RD1,  0, "rst_rd1_a");
    expect_v(0, K_RD2,  0, "rst_rd2_a");
    expect_v(0, K_DROP, 0, "rst_drop_a");
    expect_v(1, K_RDY,  0, "rst_ready_b");
    tick();

    // Release: 16 cycles not ready, a write attempt during the sweep is dropped
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_a1 = AW'(i);
      a_a2 = AW'(15 - i);
      a_we = (i == 4);
      a_a3 = 4'd5;
      a_wd = 19'h11111;
      expect_v(0, K_RDY, 0, "sweep_ready");
      expect_v(0, K_RD1, 0, "sweep_rd1");
      expect_v(0, K_RD2, 0, "sweep_rd2");
      if (i == 5) expect_v(0, K_DROP, 1, "sweep_drop_pulse");
      if (i == 6) expect_v(0, K_DROP, 0, "sweep_drop_clear");
      tick();
    end
    a_we = 0;
    expect_v(0, K_RDY, 1, "sweep_ready_up");
    expect_v(1, K_RDY, 1, "b_ready_up");

    // Every entry reads 0 after the sweep (including 5, whose write was dropped)
    for (int i = 0; i < 16; i++) begin
      a_a1 = AW'(i);
      a_a2 = AW'(i);
      expect_v(0, K_RD1, 0, "post_sweep_rd1");
      expect_v(0, K_RD2, 0, "post_sweep_rd2");
      tick();
    end

    // Full-scale write then read on both ports
    a_we = 1; a_a3 = 4'd5; a_wd = 19'h7FFFF;
    tick();
    a_we = 0; a_a1 = 4'd5; a_a2 = 4'd5;
    expect_v(0, K_RD1, 19'h7FFFF, "wr5_rd1");
    expect_v(0, K_RD2, 19'h7FFFF, "wr5_rd2");
    expect_v(0, K_DROP, 0, "wr5_nodrop");
    tick();

    // Hardwired zero register ignores writes without a drop
    a_we = 1; a_a3 = 4'd0; a_wd = 19'h12345;
    tick();
    a_we = 0; a_a1 = 4'd0;
    expect_v(0, K_RD1, 0, "zero_reg_rd1");
    expect_v(0, K_DROP, 0, "zero_reg_nodrop");
    tick();

    // Same-cycle read/write of one address
`ifdef REGFILE_BYPASS_EN
    same_cyc_exp = 19'h00ABC;
`else
    same_cyc_exp = 19'h00000;
`endif
    a_we = 1; a_a3 = 4'd3; a_wd = 19'h00ABC; a_a1 = 4'd3;
    expect_v(0, K_RD1, same_cyc_exp, "rw_same_cycle");
    tick();
    a_we = 0;
    expect_v(0, K_RD1, 19'h00ABC, "rw_after_edge");
    tick();

    // Fill 1..15 and read back
    for (int i = 1; i < 16; i++) begin
      a_we = 1; a_a3 = AW'(i); a_wd = fillv(i);
      tick();
    end
    a_we = 0;
    for (int i = 1; i < 16; i++) begin
      a_a1 = AW'(i);
      a_a2 = AW'(16 - i);
      expect_v(0, K_RD1, fillv(i), "fill_rd1");
      expect_v(0, K_RD2, fillv(16 - i), "fill_rd2");
      tick();
    end

    // clr together with a write: clear wins, drop flagged, no forwarding
    a_clr = 1; a_we = 1; a_a3 = 4'd2; a_wd = 19'h55555; a_a1 = 4'd2;
    expect_v(0, K_RD1, fillv(2), "clr_cycle_old_value");
    expect_v(0, K_RDY, 1, "clr_cycle_ready");
    tick();
    a_clr = 0; a_we = 0;
    expect_v(0, K_RDY, 0, "clr_ready_drop");
    expect_v(0, K_DROP, 1, "clr_wr_drop");
    expect_v(0, K_RD1, 0, "clr_rd1_forced");
    for (int j = 1; j < 16; j++) begin
      tick();
      a_clr = (j == 8);  // ignored mid-sweep
      expect_v(0, K_RDY, 0, "clr_sweep_ready");
      if (j == 1) expect_v(0, K_DROP, 0, "clr_drop_one_cycle");
    end
    a_clr = 0;
    tick();
    expect_v(0, K_RDY, 1, "clr_sweep_done");
    for (int i = 0; i < 16; i++) begin
      a_a1 = AW'(i);
      a_a2 = AW'(15 - i);
      expect_v(0, K_RD1, 0, "post_clr_rd1");
      expect_v(0, K_RD2, 0, "post_clr_rd2");
      tick();
    end

    // Reset asserted at idx = 7 restarts the sweep in full
    a_we = 1; a_a3 = 4'd6; a_wd = 19'h0F0F0;
    tick();
    a_we = 0; a_clr = 1;
    tick();
    a_clr = 0;
    for (int k = 1; k <= 7; k++) tick();
    rst = 1'b0;
    expect_v(0, K_RDY, 0, "midrst_ready");
    tick();
    a_a1 = 4'd6;
    expect_v(0, K_RDY, 0, "midrst_hold_ready");
    expect_v(0, K_RD1, 0, "midrst_hold_rd1");
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_v(0, K_RDY, 0, "restart_ready");
      tick();
    end
    expect_v(0, K_RDY, 1, "restart_ready_up");
    expect_v(0, K_RD1, 0, "restart_rd6_cleared");
    tick();

    // DUT b: 12 registers, register 0 writable
    b_we = 1; b_a3 = 4'd13; b_wd = 19'h01234;
    tick();
    b_we = 0; b_a1 = 4'd13;
    expect_v(1, K_RD1, 0, "b_oor13_rd1");
    expect_v(1, K_DROP, 0, "b_oor13_nodrop");
    tick();
    b_we = 1; b_a3 = 4'd0; b_wd = 19'h00055;
    tick();
    b_we = 0; b_a2 = 4'd0;
    expect_v(1, K_RD2, 19'h00055, "b_reg0_rd2");
    tick();
    b_we = 1; b_a3 = 4'd11; b_wd = 19'h7ABCD;
    tick();
    b_we = 1; b_a3 = 4'd12; b_wd = 19'h00003;
    b_a1 = 4'd11;
    expect_v(1, K_RD1, 19'h7ABCD, "b_last_reg_rd1");
    tick();
    b_we = 0; b_a1 = 4'd12;
    expect_v(1, K_RD1, 0, "b_oor12_rd1");
    tick();

    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
